// File: rtl/word_serializer_16.sv
// word_serializer_16: captures a parallel word and streams it out bit-serially over a VALID/SREADY handshake
module word_serializer_16 #(
  parameter int WIDTH     = 16,
  parameter bit LSB_FIRST = 1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] D,
  input  logic             LOAD,
  output logic             READY,
  output logic             SOUT,
  output logic             VALID,
  input  logic             SREADY,
  output logic             DONE
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_FINISH} state_t;
  state_t           r_state, w_next;
  logic [WIDTH-1:0] r_shift, w_shifted;
  logic [CW-1:0]    r_cnt;
  logic             w_xfer, w_last;
  // next state, transfer strobe and shifted word
  always_comb begin
    w_xfer    = (r_state == S_SHIFT) && SREADY;
    w_last    = r_cnt == CW'(WIDTH - 1);
    w_shifted = LSB_FIRST ? r_shift >> 1 : r_shift << 1;
    w_next    = r_state == S_IDLE  ? (LOAD ? S_SHIFT : S_IDLE) :
                r_state == S_SHIFT ? (w_xfer && w_last ? S_FINISH : S_SHIFT) : S_IDLE;
  end
  // state register
  always_ff @(posedge CLK or posedge RST)
    if (RST) r_state <= S_IDLE;
    else     r_state <= w_next;
  // shift register and bit counter; counter holds on the last bit so it never wraps
  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      r_shift <= '0;
      r_cnt   <= '0;
    end else if (r_state == S_IDLE && LOAD) begin
      r_shift <= D;
      r_cnt   <= '0;
    end else if (w_xfer) begin
      r_shift <= w_shifted;
      r_cnt   <= w_last ? r_cnt : r_cnt + CW'(1);
    end
  assign READY = r_state == S_IDLE;
  assign VALID = r_state == S_SHIFT;
  assign DONE  = r_state == S_FINISH;
  assign SOUT  = VALID && (LSB_FIRST ? r_shift[0] : r_shift[WIDTH-1]);
endmodule

// File: tb/tb_word_serializer_16.sv
// tb_word_serializer_16: randomized and directed checks of both bit orders against a word-level reference model
module tb_word_serializer_16;
  logic        CLK = 0, RST = 1, LOAD = 0, SREADY = 0;
  logic [15:0] D = '0;
  logic [1:0]  rdy, so, vld, dn;
  int          total = 0, bad = 0, n = 0;
  logic [15:0] m_word [2];
  int          m_pos  [2];
  bit          m_fin  [2];
  int          acc_e = -1, gap = -1, dcnt0 = 0, dcnt1 = 0;
  int          d_at, r_at;

  word_serializer_16 #(.WIDTH(16), .LSB_FIRST(1)) dut (
    .CLK(CLK), .RST(RST), .D(D), .LOAD(LOAD), .READY(rdy[0]), .SOUT(so[0]),
    .VALID(vld[0]), .SREADY(SREADY), .DONE(dn[0]));
  word_serializer_16 #(.WIDTH(16), .LSB_FIRST(0)) dut_m (
    .CLK(CLK), .RST(RST), .D(D), .LOAD(LOAD), .READY(rdy[1]), .SOUT(so[1]),
    .VALID(vld[1]), .SREADY(SREADY), .DONE(dn[1]));

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_pos[k] = -1;
      m_fin[k] = 0;
    end
  endtask

  // compare both DUTs against the model, then advance one clock
  task automatic tick(input logic l, input logic [15:0] d, input logic s);
    logic ev, eb;
    LOAD = l; D = d; SREADY = s;
    for (int k = 0; k < 2; k++) begin
      ev = m_pos[k] >= 0;
      eb = ev && (k == 0 ? m_word[k][m_pos[k]] : m_word[k][15 - m_pos[k]]);
      chk($sformatf("ready%0d@%0d", k, n), rdy[k], !ev && !m_fin[k]);
      chk($sformatf("valid%0d@%0d", k, n), vld[k], ev);
      chk($sformatf("sout%0d@%0d", k, n), so[k], eb);
      chk($sformatf("done%0d@%0d", k, n), dn[k], m_fin[k]);
    end
    if (rdy[0] && l && !RST) begin
      if (acc_e >= 0) gap = n + 1 - acc_e;
      acc_e = n + 1;
    end
    dcnt0 += int'(dn[0]);
    dcnt1 += int'(dn[1]);
    @(posedge CLK);
    n++;
    for (int k = 0; k < 2; k++)
      if (RST) begin
        m_pos[k] = -1; m_fin[k] = 0;
      end else if (m_fin[k]) m_fin[k] = 0;
      else if (m_pos[k] < 0) begin
        if (l) begin m_word[k] = d; m_pos[k] = 0; end
      end else if (s) begin
        if (m_pos[k] == 15) begin m_pos[k] = -1; m_fin[k] = 1; end
        else m_pos[k]++;
      end
    #1;
  endtask

  // one accepted word; optional stall of stall_len cycles after stall_after transfers
  task automatic run_word(input logic [15:0] d, input int stall_after, input int stall_len,
                          output int o_done, output int o_ready);
    int x, st;
    logic s;
    x = 0; st = 0; o_done = -1; o_ready = -1;
    tick(1, d, 1);
    for (int i = 1; i < 45 && o_ready < 0; i++) begin
      s = !(x == stall_after && st < stall_len);
      if (dn[0] && o_done < 0) o_done = i;
      if (rdy[0]) o_ready = i;
      if (!s) st++;
      if (vld[0] && s) x++;
      tick(0, 16'h0000, s);
    end
  endtask

  initial begin
    model_reset();
    #1;
    chk("rst_ready", rdy, 2'b11);
    chk("rst_valid", vld, 2'b00);
    chk("rst_sout", so, 2'b00);
    chk("rst_done", dn, 2'b00);
    tick(1, 16'hFFFF, 1);
    tick(1, 16'hFFFF, 1);
    RST = 0;
    tick(0, 16'h0, 0);

    run_word(16'h000F, -1, 0, d_at, r_at);
    chk("basic_done_lat", d_at, 17);
    chk("basic_ready_lat", r_at, 18);

    dcnt1 = 0;
    run_word(16'h8001, -1, 0, d_at, r_at);
    chk("msb_done_cnt", dcnt1, 1);

    run_word(16'h00FF, 4, 3, d_at, r_at);
    chk("stall_done_lat", d_at, 20);
    chk("stall_ready_lat", r_at, 21);

    dcnt0 = 0;
    tick(1, 16'h0F0F, 1);
    for (int i = 0; i < 24; i++) tick(i == 5 || i == 16, 16'hFFFF, 1);
    chk("ignored_load_done_cnt", dcnt0, 1);

    gap = -1;
    for (int i = 0; i < 18; i++) tick(1, 16'h1234, 1);
    for (int i = 0; i < 4; i++) tick(1, 16'h5678, 1);
    for (int i = 0; i < 16; i++) tick(0, 16'h0, 1);
    chk("b2b_gap", gap, 18);

    dcnt0 = 0;
    tick(1, 16'hA5C3, 1);
    for (int i = 0; i < 5; i++) tick(0, 16'h0, 1);
    #2 RST = 1;
    #1;
    model_reset();
    chk("async_rst_ready", rdy, 2'b11);
    chk("async_rst_valid", vld, 2'b00);
    chk("async_rst_sout", so, 2'b00);
    chk("async_rst_done", dn, 2'b00);
    @(posedge CLK); #1;
    tick(0, 16'h0, 1);
    RST = 0;
    for (int i = 0; i < 20; i++) tick(0, 16'h0, 1);
    chk("rst_no_done", dcnt0, 0);
    run_word(16'hA5C3, -1, 0, d_at, r_at);
    chk("post_rst_done_lat", d_at, 17);

    for (int i = 0; i < 400; i++)
      tick($urandom_range(0, 9) < 3, 16'($urandom), $urandom_range(0, 3) != 0);
    for (int i = 0; i < 40; i++) tick(0, 16'h0, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
